// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef struct packed {
    logic [15:0] prefill;
    logic [15:0] clear;
    logic [15:0] flush;
  } phase_len_t;

  // Fixed phase lengths in cycles: one weight row per prefill cycle, one
  // extra clear cycle so the corner PE sees zero operands, and enough
  // flush cycles for the last window to cross the far corner.
  function automatic phase_len_t phase_lens(input int rows, input int cols);
    phase_len_t p;
    p.prefill = 16'(rows);
    p.clear   = 16'(rows + 1);
    p.flush   = 16'(rows + cols - 1);
    return p;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Skew delay line: lane i carries the input delayed by i+1 register stages.
// Latency: 1 cycle into lane 0, one more per lane.
// Backpressure: none; synchronous clear empties every lane.
module skew_line #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] lanes
);

  // Shift the new window bit into lane 0; clear wipes all lanes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
    end else if (clr) begin
      lanes <= '0;
    end else begin
      lanes <= N'({lanes, din});
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a ROWS x COLS systolic MAC array (WS and OS modes).
// Latency: every output registered; busy rises one cycle after accepted start.
// Backpressure: start only taken in IDLE; abort returns to IDLE next cycle.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_W  = 8,
  localparam int WR  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            cfg_os,
  input  logic [K_W-1:0]  cfg_k,
  output logic            busy,
  output logic            done,
  output logic            prefill,
  output logic            os_en,
  output logic [WR-1:0]   wt_row,
  output logic [ROWS-1:0] row_feed_en,
  output logic [COLS-1:0] col_feed_en,
  output logic [COLS-1:0] col_out_valid,
  output logic            result_valid
);

  localparam int         CNT_MIN = $clog2(ROWS + COLS + 1);
  localparam int         CW      = (CNT_MIN > K_W) ? CNT_MIN : K_W;
  localparam phase_len_t PH      = phase_lens(ROWS, COLS);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PH.prefill - 16'd1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(PH.clear - 16'd1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(PH.flush - 16'd1);

  seq_state_t     state, nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           mode_q, mode_nxt;
  logic [K_W-1:0] k_q, k_nxt;
  logic [CW-1:0]  k_last;
  logic           w_nxt, line_clr, col_din;
  logic [ROWS-1:0] row_lanes;
  logic [COLS-1:0] col_lanes;

  assign k_last = CW'(k_q) - CW'(1);

  // FSM state, cycle counter and latched job configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_q <= MODE_WS;
      k_q    <= '0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
      k_q    <= k_nxt;
    end
  end

  // Next state: the counter holds cycles left in the phase, so in PREFILL
  // it doubles as the weight row index (bottom row first).
  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    mode_nxt = mode_q;
    k_nxt    = k_q;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          mode_nxt = cfg_os;
          k_nxt    = cfg_k;
          if (cfg_os == MODE_OS) begin
            nxt     = ST_CLEAR;
            cnt_nxt = CLR_LAST;
          end else begin
            nxt     = ST_PREFILL;
            cnt_nxt = PRE_LAST;
          end
        end
      end
      ST_PREFILL, ST_CLEAR: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (k_q == '0) begin
          nxt     = ST_FLUSH;
          cnt_nxt = FLUSH_LAST;
        end else begin
          nxt     = ST_STREAM;
          cnt_nxt = k_last;
        end
      end
      ST_STREAM: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          nxt     = ST_FLUSH;
          cnt_nxt = FLUSH_LAST;
        end
      end
      ST_FLUSH: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          nxt = (mode_q == MODE_OS) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) begin
      nxt = ST_IDLE;
    end
  end

  // The window bit is generated one cycle early so lane 0 is already a flop.
  // WS reuses the column line to time col_out_valid off the bottom row lane.
  assign w_nxt    = (nxt == ST_STREAM);
  assign line_clr = (nxt == ST_IDLE);
  assign col_din  = (mode_q == MODE_OS) ? w_nxt : row_lanes[ROWS-1];

  skew_line #(.N(ROWS)) u_row_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (line_clr),
    .din   (w_nxt),
    .lanes (row_lanes)
  );

  skew_line #(.N(COLS)) u_col_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (line_clr),
    .din   (col_din),
    .lanes (col_lanes)
  );

  // Mode only changes in IDLE while both lines are empty, so these selects
  // never switch under a live window.
  assign row_feed_en   = row_lanes;
  assign col_feed_en   = (mode_q == MODE_OS) ? col_lanes : {COLS{prefill}};
  assign col_out_valid = (mode_q == MODE_WS) ? col_lanes : '0;

  // Array-wide controls registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      prefill      <= 1'b0;
      os_en        <= 1'b0;
      wt_row       <= '0;
      result_valid <= 1'b0;
    end else begin
      busy         <= (nxt != ST_IDLE) && (nxt != ST_DONE);
      done         <= (nxt == ST_DONE);
      prefill      <= (nxt == ST_PREFILL);
      os_en        <= (mode_nxt == MODE_OS) &&
                      ((nxt == ST_STREAM) || (nxt == ST_FLUSH) || (nxt == ST_DRAIN));
      wt_row       <= (nxt == ST_PREFILL) ? cnt_nxt[WR-1:0] : '0;
      result_valid <= (nxt == ST_DRAIN);
    end
  end

endmodule
